// File: rtl/cla_sweep_checker.sv
// Bring-up sequencer for a registered 4-bit CLA: sweeps all 512 {x,y,cin} vectors,
// checks each result against a delayed expected sum and keeps error statistics.
module cla_sweep_checker #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:1] x,
  output logic [4:1] y,
  output logic       cin,
  input  logic       cout,
  input  logic [4:1] z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [8:0] first_fail,
  output logic [4:0] first_got,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [8:0] idx;
  logic [8:0] drv, drv_nxt;
  logic       seen_fail;

  // Expected pipe: stage 0 is loaded on the edge that drives the vector,
  // stage LAT is what gets compared on edge E_{k+LAT+1}.
  logic [LAT:0]      pv;
  logic [LAT:0][8:0] pidx;
  logic [LAT:0][4:0] pexp;

  logic       push_v;
  logic [8:0] push_idx;
  logic [4:0] push_exp;
  logic       start_sweep;
  logic       cmp_en;
  logic       mism;

  function automatic logic [4:0] vec_sum(input logic [8:0] v);
    return {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_sweep = 1'b0;
    push_v      = 1'b0;
    push_idx    = '0;
    push_exp    = '0;
    drv_nxt     = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_sweep = 1'b1;
          push_v      = 1'b1;
          state_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        if (idx == 9'd511) begin
          state_nxt = S_DRAIN;
        end else begin
          drv_nxt  = idx + 9'd1;
          push_v   = 1'b1;
          push_idx = idx + 9'd1;
          push_exp = vec_sum(idx + 9'd1);
        end
      end
      S_DRAIN: begin
        // stage LAT is being consumed this edge, so only the younger stages matter
        if (pv[LAT-1:0] == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmp_en = ((state == S_RUN) || (state == S_DRAIN)) && pv[LAT];
  assign mism   = cmp_en && ({cout, z} != pexp[LAT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      drv        <= '0;
      pv         <= '0;
      pidx       <= '0;
      pexp       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      first_got  <= '0;
      seen_fail  <= 1'b0;
    end else begin
      drv     <= drv_nxt;
      pv[0]   <= push_v;
      pidx[0] <= push_idx;
      pexp[0] <= push_exp;
      for (int i = 1; i <= LAT; i++) begin
        pv[i]   <= start_sweep ? 1'b0 : pv[i-1];
        pidx[i] <= start_sweep ? '0   : pidx[i-1];
        pexp[i] <= start_sweep ? '0   : pexp[i-1];
      end
      if (start_sweep) begin
        idx        <= '0;
        err_count  <= '0;
        first_fail <= '0;
        first_got  <= '0;
        seen_fail  <= 1'b0;
      end else begin
        if (state == S_RUN && idx != 9'd511) idx <= idx + 9'd1;
        if (mism) begin
          if (err_count != 8'd255) err_count <= err_count + 8'd1;
          if (!seen_fail) begin
            first_fail <= pidx[LAT];
            first_got  <= {cout, z};
            seen_fail  <= 1'b1;
          end
        end
      end
    end
  end

  assign x         = drv[8:5];
  assign y         = drv[4:1];
  assign cin       = drv[0];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == 8'd0);
  assign dbg_state = state;

endmodule

// File: tb/tb_cla_sweep_checker.sv
// Bench for cla_sweep_checker: behavioural adder with injectable faults, an
// arithmetic reference of the whole sweep, and directed/randomised sweeps.
module tb_cla_sweep_checker;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:1] x, y, z;
  logic       cin, cout;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [8:0] first_fail;
  logic [4:0] first_got;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

  // adder environment: 0 ideal, 1 z[1] stuck 0, 2 cout flip on 117,
  // 3 ideal but latency 1, 4 random mask on a random vector
  int         mode = 0;
  int         adder_lat = 2;
  logic [8:0] fault_vec = '0;
  logic [4:0] fault_mask = '0;
  logic [4:0] a1, a2;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int         busy_cycles = 0;

  cla_sweep_checker #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .y(y), .cin(cin), .cout(cout), .z(z),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .first_got(first_got),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic int ideal_sum(input int v);
    return ((v >> 5) & 15) + ((v >> 1) & 15) + (v & 1);
  endfunction

  function automatic logic [4:0] adder_fn(input int m, input int v);
    int s;
    s = ideal_sum(v);
    if (m == 1) s = s & ~1;
    if (m == 2 && v == 117) s = s ^ 16;
    if (m == 4 && v == int'(fault_vec)) s = s ^ int'(fault_mask);
    return s[4:0];
  endfunction

  always @(posedge clk) begin
    a1 <= adder_fn(mode, int'({x, y, cin}));
    a2 <= a1;
  end
  assign {cout, z} = (adder_lat == 1) ? a1 : a2;

  always @(negedge clk) begin
    if (busy) begin
      obs_q.push_back({x, y, cin});
      busy_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference: what the checker must report after a full sweep in the given environment
  task automatic model_sweep(input int m, output int e_err, output int e_ff, output int e_fg);
    int e, g;
    bit seen;
    e_err = 0; e_ff = 0; e_fg = 0; seen = 0;
    for (int k = 0; k < 512; k++) begin
      e = ideal_sum(k);
      if (m == 3) g = (k < 511) ? ideal_sum(k + 1) : 0;
      else        g = int'(adder_fn(m, k));
      if (g != e) begin
        if (e_err < 255) e_err++;
        if (!seen) begin
          e_ff = k; e_fg = g; seen = 1;
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    obs_q.delete();
    busy_cycles = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_done_drop", {done, pass}, 2'b00);
    check("start_busy", busy, 1'b1);
  endtask

  task automatic wait_done(input bit repulse);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
      if (repulse) start = (busy && {x, y, cin} == 9'd50) || (dbg_state == 2'd2);
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_results(input string tag, input int m);
    int e_err, e_ff, e_fg, nbad;
    model_sweep(m, e_err, e_ff, e_fg);
    check({tag, "_err_count"}, err_count, e_err);
    check({tag, "_first_fail"}, first_fail, e_ff);
    check({tag, "_first_got"}, first_got, e_fg);
    check({tag, "_pass"}, pass, (e_err == 0));
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_busy_cycles"}, busy_cycles, 512 + LAT);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(9'(k));
    for (int k = 0; k < LAT; k++) exp_q.push_back(9'd0);
    nbad = (obs_q.size() == exp_q.size()) ? 0 : 1000;
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      if (obs_q[k] !== exp_q[k]) nbad++;
    check({tag, "_vector_seq"}, nbad, 0);
  endtask

  task automatic sweep(input string tag, input int m, input int lat, input bit repulse);
    mode = m;
    adder_lat = lat;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    do_start();
    wait_done(repulse);
    check_results(tag, m);
  endtask

  initial begin
    int hit;
    repeat (3) @(negedge clk);
    check("reset_outputs", {x, y, cin, busy, done, pass, err_count, first_fail, first_got}, 0);
    check("reset_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, done, x, y, cin}, 0);

    sweep("ideal", 0, 2, 1'b0);
    check("ideal_exact_pass", {pass, err_count}, 9'h100);
    sweep("z1_stuck", 1, 2, 1'b0);
    check("z1_stuck_spec", {err_count, first_fail, first_got}, {8'd255, 9'd1, 5'b00000});
    sweep("cout_117", 2, 2, 1'b0);
    check("cout_117_spec", {err_count, first_fail, first_got}, {8'd1, 9'd117, 5'b11110});
    sweep("lat1", 3, 1, 1'b0);
    check("lat1_spec", {pass, first_fail, first_got}, {1'b0, 9'd0, 5'b00001});

    // asynchronous reset mid-sweep, with errors already accumulated
    mode = 1;
    adder_lat = 2;
    do_start();
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ({x, y, cin} == 9'd100) begin
        hit = 1;
        break;
      end
    end
    check("reset_reached_idx100", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {x, y, cin, busy, done, pass, err_count, first_fail, first_got}, 0);
    check("midreset_state", dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", {busy, done, dbg_state}, 0);
    sweep("after_reset", 0, 2, 1'b0);

    sweep("repulse", 0, 2, 1'b1);
    sweep("restart_done", 0, 2, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fault_vec = 9'($urandom_range(0, 511));
      fault_mask = 5'($urandom_range(1, 31));
      sweep($sformatf("rand%0d", r), 4, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
